io_bus_arbiter: RTL
===================

// Module: io_bus_arbiter
// PURPOSE
//   Two-master arbiter for the LSU memory-mapped I/O/data bus. Shares one target port (LEDR/LEDG/HEX/LCD
//   regs + data RAM) between the single-cycle core (M0) and the debug/loader master (M1).
//   Round-robin with bounded bursts, stall-by-grant handshake, in-order read-return tracking.
// PARAMETERS
//   ADDR_W      32  address width
//   DATA_W      32  data width
//   RD_LATENCY  1   cycles from read transfer to i_s_rdata valid (1..4)
//   MAX_BURST   4   max consecutive transfers by owner while other master requests (1..15)
// PORTS
//   i_clk        in   1           clock
//   i_reset      in   1           asynchronous reset, active-low
//   i_mX_req     in   1           X=0,1: transfer request; hold req/wren/addr/wdata/bmask stable until gnt
//   i_mX_wren    in   1           1=write, 0=read
//   i_mX_addr    in   ADDR_W      byte address
//   i_mX_wdata   in   DATA_W      write data
//   i_mX_bmask   in   DATA_W/8    byte enables
//   o_mX_gnt     out  1           transfer accepted this cycle (req & gnt at posedge = transfer)
//   o_mX_rvalid  out  1           read data valid for master X
//   o_mX_rdata   out  DATA_W      read data; 0 when o_mX_rvalid=0
//   o_s_en       out  1           target access this cycle
//   o_s_wren     out  1           target write enable
//   o_s_addr     out  ADDR_W      target address
//   o_s_wdata    out  DATA_W      target write data
//   o_s_bmask    out  DATA_W/8    target byte enables
//   i_s_rdata    in   DATA_W      target read data, valid RD_LATENCY cycles after read o_s_en
// BEHAVIOUR
//   State: owner (0/1), burst_cnt (4b), return pipe of RD_LATENCY stages {vld, id}.
//   Reset (i_reset=0, async): owner=M0, burst_cnt=0, return pipe cleared; while low all gnt,
//     o_s_en, o_s_wren, rvalid = 0 and o_s_addr/wdata/bmask, rdata = 0. In-flight reads dropped.
//   Grant (combinational, same cycle, at most one gnt):
//     - only one master requesting -> that master.
//     - both requesting -> owner, unless burst_cnt == MAX_BURST -> other master.
//     - none -> no grant.
//   Per posedge with transfer by master g: if g==owner, burst_cnt=min(burst_cnt+1, MAX_BURST)
//     else owner=g, burst_cnt=1. No transfer: owner held, burst_cnt=0.
//   Target mux: o_s_* driven from granted master; no grant -> o_s_en=0, o_s_wren=0, addr/wdata/bmask=0
//     (no spurious HEX/LED writes).
//   Read return: read transfer pushes {1,g} into return pipe; o_mg_rvalid=1 exactly RD_LATENCY
//     cycles later for one cycle, o_mg_rdata=i_s_rdata. Writes push {0,x}; no rvalid. Returns strictly in
//     issue order; reads may issue back-to-back every cycle (pipe never stalls).
//   Requester without gnt stalls (core holds PC); no timeout, no drop of held request.
//   Simultaneous: read return to one master and new grant to other in same cycle are independent.
//   Reset released mid-burst: arbitration restarts with M0 preference only via owner=M0.
// TESTING
//   1 M0 write addr 0x7020 data 0x0000_0040 bmask 0xF, M1 idle -> o_m0_gnt=1, o_s_en=1, o_s_wren=1
//     same cycle, no rvalid on either master.
//   2 Both req writes continuously, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,0,...
//   3 M0 read 0x1000, RD_LATENCY=2, i_s_rdata=0xDEAD_BEEF -> o_m0_rvalid=1 exactly 2 cycles after
//     transfer, rdata=0xDEAD_BEEF; o_m1_rvalid stays 0.
//   4 Alternating single reads M0,M1,M0 on consecutive cycles -> rvalid m0,m1,m0 on consecutive cycles
//     RD_LATENCY later, each with its matching i_s_rdata.
//   5 Assert i_reset=0 one cycle after M1 read (RD_LATENCY=2) -> no o_m1_rvalid after release;
//     with both then requesting, first gnt goes to M0.
//   6 M1 drops req after 2 of burst with M0 waiting -> M0 granted next cycle, burst_cnt restarts at 1.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter sharing one memory-mapped target port between the core (M0) and
// the debug/loader master (M1), with bounded bursts and in-order read-return tracking.
module io_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_m0_req,
  input  logic                i_m0_wren,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  input  logic [DATA_W/8-1:0] i_m0_bmask,
  output logic                o_m0_gnt,
  output logic                o_m0_rvalid,
  output logic [DATA_W-1:0]   o_m0_rdata,
  input  logic                i_m1_req,
  input  logic                i_m1_wren,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_bmask,
  output logic                o_m1_gnt,
  output logic                o_m1_rvalid,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic                o_s_en,
  output logic                o_s_wren,
  output logic [ADDR_W-1:0]   o_s_addr,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_bmask,
  input  logic [DATA_W-1:0]   i_s_rdata
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  logic                  owner_q, owner_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic [RD_LATENCY-1:0] rp_vld_q, rp_vld_d;
  logic [RD_LATENCY-1:0] rp_id_q, rp_id_d;

  logic gnt0, gnt1;
  logic xfer, xfer_id, xfer_rd;

  // Grants are suppressed while reset is held so no target access can leak out.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_reset) begin
      if (i_m0_req && i_m1_req) begin
        if (burst_cnt_q == MAX_CNT) begin
          gnt0 = owner_q;
          gnt1 = ~owner_q;
        end else begin
          gnt0 = ~owner_q;
          gnt1 = owner_q;
        end
      end else begin
        gnt0 = i_m0_req;
        gnt1 = i_m1_req;
      end
    end
  end

  assign xfer    = gnt0 | gnt1;
  assign xfer_id = gnt1;
  assign xfer_rd = (gnt0 & ~i_m0_wren) | (gnt1 & ~i_m1_wren);

  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer) begin
      if (xfer_id == owner_q) begin
        burst_cnt_d = (burst_cnt_q == MAX_CNT) ? MAX_CNT : burst_cnt_q + 4'd1;
      end else begin
        owner_d     = xfer_id;
        burst_cnt_d = 4'd1;
      end
    end else begin
      burst_cnt_d = 4'd0;
    end
  end

  // Return pipe shifts every cycle; the last stage lines up with the target's read data.
  always_comb begin
    rp_vld_d = rp_vld_q;
    rp_id_d  = rp_id_q;
    for (int i = RD_LATENCY - 1; i > 0; i--) begin
      rp_vld_d[i] = rp_vld_q[i-1];
      rp_id_d[i]  = rp_id_q[i-1];
    end
    rp_vld_d[0] = xfer_rd;
    rp_id_d[0]  = xfer_id;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      owner_q     <= 1'b0;
      burst_cnt_q <= 4'd0;
      rp_vld_q    <= '0;
      rp_id_q     <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rp_vld_q    <= rp_vld_d;
      rp_id_q     <= rp_id_d;
    end
  end

  assign o_m0_gnt = gnt0;
  assign o_m1_gnt = gnt1;

  assign o_s_en    = xfer;
  assign o_s_wren  = (gnt0 & i_m0_wren) | (gnt1 & i_m1_wren);
  assign o_s_addr  = gnt0 ? i_m0_addr  : (gnt1 ? i_m1_addr  : '0);
  assign o_s_wdata = gnt0 ? i_m0_wdata : (gnt1 ? i_m1_wdata : '0);
  assign o_s_bmask = gnt0 ? i_m0_bmask : (gnt1 ? i_m1_bmask : '0);

  assign o_m0_rvalid = rp_vld_q[RD_LATENCY-1] & ~rp_id_q[RD_LATENCY-1];
  assign o_m1_rvalid = rp_vld_q[RD_LATENCY-1] &  rp_id_q[RD_LATENCY-1];
  assign o_m0_rdata  = o_m0_rvalid ? i_s_rdata : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_s_rdata : '0;

endmodule
